// File: rtl/mainm_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM encoding and port ids.
package mainm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mainm_arb_pick.sv
// Winner select between CPU and DMA requests.
// MAINM_ARB_RR_EN: contention resolved by rr_ptr; otherwise DMA always wins.
module mainm_arb_pick
  import mainm_arb_pkg::*;
(
`ifdef MAINM_ARB_RR_EN
  input  logic rr_ptr,
`endif
  input  logic c_req,
  input  logic x_req,
  output logic winner
);

  always_comb begin
    winner = PORT_CPU;
    if (c_req && x_req) begin
`ifdef MAINM_ARB_RR_EN
      winner = rr_ptr;
`else
      winner = PORT_DMA;
`endif
    end else if (x_req) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mainm_arbiter.sv
// Two-port arbiter sharing the PSRAM controller between the CPU path and a DMA master.
// MAINM_ARB_RR_EN selects round-robin on contention; default is fixed DMA-over-CPU priority.
module mainm_arbiter
  import mainm_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] c_a,
  input  logic [DW-1:0] c_d,
  input  logic          c_we,
  input  logic          c_rd,
  output logic [DW-1:0] c_spo,
  output logic          c_ready,
  input  logic [AW-1:0] x_a,
  input  logic [DW-1:0] x_d,
  input  logic          x_we,
  input  logic          x_rd,
  output logic [DW-1:0] x_spo,
  output logic          x_ready,
  output logic [AW-1:0] m_a,
  output logic [DW-1:0] m_d,
  output logic          m_we,
  output logic          m_rd,
  input  logic [DW-1:0] m_spo,
  input  logic          m_ready,
  output logic          owner,
  output logic          busy
);

  // state       | meaning
  // ARB_IDLE    | sample requests, grant folds into the IDLE->WAIT edge
  // ARB_WAIT    | m_* held, waiting for controller m_ready
  // ARB_RELEASE | dead cycle so the requester can drop we/rd

  arb_state_e    state_q, state_d;
  logic [AW-1:0] m_a_q, m_a_d;
  logic [DW-1:0] m_d_q, m_d_d;
  logic          m_we_q, m_we_d;
  logic          m_rd_q, m_rd_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] c_spo_q, c_spo_d;
  logic [DW-1:0] x_spo_q, x_spo_d;
  logic          c_req, x_req, win, done;

  assign c_req = c_we | c_rd;
  assign x_req = x_we | x_rd;
  assign done  = (state_q == ARB_WAIT) && m_ready;

`ifdef MAINM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  mainm_arb_pick u_pick (
    .rr_ptr (rr_ptr_q),
    .c_req  (c_req),
    .x_req  (x_req),
    .winner (win)
  );

  // After any grant the other port is favoured next.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB_IDLE && (c_req || x_req)) rr_ptr_d = ~win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= PORT_CPU;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  mainm_arb_pick u_pick (
    .c_req  (c_req),
    .x_req  (x_req),
    .winner (win)
  );
`endif

  always_comb begin
    state_d = state_q;
    m_a_d   = m_a_q;
    m_d_d   = m_d_q;
    m_we_d  = m_we_q;
    m_rd_d  = m_rd_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    c_spo_d = c_spo_q;
    x_spo_d = x_spo_q;
    case (state_q)
      ARB_IDLE: begin
        if (c_req || x_req) begin
          state_d = ARB_WAIT;
          owner_d = win;
          busy_d  = 1'b1;
          if (win == PORT_DMA) begin
            m_a_d  = x_a;
            m_d_d  = x_d;
            m_we_d = x_we;
            m_rd_d = x_rd & ~x_we;
          end else begin
            m_a_d  = c_a;
            m_d_d  = c_d;
            m_we_d = c_we;
            m_rd_d = c_rd & ~c_we;
          end
        end
      end
      ARB_WAIT: begin
        if (m_ready) begin
          state_d = ARB_RELEASE;
          m_we_d  = 1'b0;
          m_rd_d  = 1'b0;
          busy_d  = 1'b0;
          if (owner_q == PORT_DMA) x_spo_d = m_spo;
          else                     c_spo_d = m_spo;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      m_a_q   <= '0;
      m_d_q   <= '0;
      m_we_q  <= 1'b0;
      m_rd_q  <= 1'b0;
      owner_q <= PORT_CPU;
      busy_q  <= 1'b0;
      c_spo_q <= '0;
      x_spo_q <= '0;
    end else begin
      state_q <= state_d;
      m_a_q   <= m_a_d;
      m_d_q   <= m_d_d;
      m_we_q  <= m_we_d;
      m_rd_q  <= m_rd_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      c_spo_q <= c_spo_d;
      x_spo_q <= x_spo_d;
    end
  end

  // Completion data bypasses the holding register so ready and spo arrive together.
  assign c_ready = done && (owner_q == PORT_CPU);
  assign x_ready = done && (owner_q == PORT_DMA);
  assign c_spo   = c_ready ? m_spo : c_spo_q;
  assign x_spo   = x_ready ? m_spo : x_spo_q;
  assign m_a     = m_a_q;
  assign m_d     = m_d_q;
  assign m_we    = m_we_q;
  assign m_rd    = m_rd_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mainm_arbiter.sv
// Scoreboard bench for mainm_arbiter: requester/controller models drive the DUT,
// a monitor checks every grant and every port completion against queued expectations.
module tb_mainm_arbiter;

  logic        clk, rst_n;
  logic [31:0] c_a, c_d, c_spo, x_a, x_d, x_spo, m_a, m_d, m_spo;
  logic        c_we, c_rd, c_ready, x_we, x_rd, x_ready;
  logic        m_we, m_rd, m_ready, owner, busy;

  mainm_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_a(c_a), .c_d(c_d), .c_we(c_we), .c_rd(c_rd), .c_spo(c_spo), .c_ready(c_ready),
    .x_a(x_a), .x_d(x_d), .x_we(x_we), .x_rd(x_rd), .x_spo(x_spo), .x_ready(x_ready),
    .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd), .m_spo(m_spo), .m_ready(m_ready),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
  } req_t;

  typedef struct {
    logic        own;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
  } grant_t;

  typedef struct {
    logic        port;
    logic [31:0] spo;
    logic        chk;
  } done_t;

  req_t   cpu_q[$];
  req_t   dma_q[$];
  grant_t grant_q[$];
  done_t  done_q[$];

  int total = 0;
  int bad   = 0;
  int cpu_gr = 0;
  int dma_gr = 0;

  logic        c_act, x_act;
  logic        ctl_en, man_ready;
  int          ctl_lat, ctl_cnt;
  logic [31:0] ctl_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic exp_grant(input logic own, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic rd);
    grant_t g;
    g.own = own; g.a = a; g.d = d; g.we = we; g.rd = rd;
    grant_q.push_back(g);
  endtask

  task automatic exp_done(input logic port, input logic [31:0] spo, input logic chk);
    done_t e;
    e.port = port; e.spo = spo; e.chk = chk;
    done_q.push_back(e);
  endtask

  task automatic push_req(input logic dma, input logic [31:0] a, input logic [31:0] d,
                          input logic we, input logic rd);
    req_t r;
    r.a = a; r.d = d; r.we = we; r.rd = rd;
    if (dma) dma_q.push_back(r);
    else     cpu_q.push_back(r);
  endtask

  // One clock: requester models and controller model update #1 after the edge.
  task automatic tick();
    logic cr, xr, mreq;
    req_t r;
    @(negedge clk);
    cr = c_ready; xr = x_ready; mreq = m_we | m_rd;
    @(posedge clk);
    #1;
    if (c_act && cr) begin c_we = 0; c_rd = 0; c_act = 0; end
    if (x_act && xr) begin x_we = 0; x_rd = 0; x_act = 0; end
    if (!c_act && cpu_q.size() > 0) begin
      r = cpu_q.pop_front();
      c_a = r.a; c_d = r.d; c_we = r.we; c_rd = r.rd; c_act = 1;
    end
    if (!x_act && dma_q.size() > 0) begin
      r = dma_q.pop_front();
      x_a = r.a; x_d = r.d; x_we = r.we; x_rd = r.rd; x_act = 1;
    end
    if (ctl_en) begin
      if (m_ready) begin
        m_ready = 0; m_spo = 32'hDEAD_DEAD; ctl_cnt = 0;
      end else if (mreq) begin
        ctl_cnt++;
        if (ctl_cnt == ctl_lat) begin
          m_ready = 1; m_spo = ctl_data ^ m_a; ctl_cnt = 0;
        end
      end else begin
        ctl_cnt = 0;
      end
    end else begin
      m_ready = man_ready;
      m_spo   = man_ready ? ctl_data : 32'hDEAD_DEAD;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    c_we = 0; c_rd = 0; c_act = 0; x_we = 0; x_rd = 0; x_act = 0;
    m_ready = 0; man_ready = 0; ctl_cnt = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while ((done_q.size() > 0 || grant_q.size() > 0 || cpu_q.size() > 0 ||
            dma_q.size() > 0 || c_act || x_act) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: timeout after %0d cycles, %0d grants %0d completions pending",
               nm, n, grant_q.size(), done_q.size());
    end
  endtask

  // Monitor: new grant on rising m_we|m_rd, completion on any port ready.
  initial begin
    logic   prev_mreq;
    grant_t g;
    done_t  e;
    prev_mreq = 0;
    forever begin
      @(negedge clk);
      if ((m_we | m_rd) && !prev_mreq) begin
        if (owner) dma_gr++; else cpu_gr++;
        if (grant_q.size() == 0) begin
          check("unexpected_grant", {owner, m_a, m_d, m_we, m_rd}, '0);
        end else begin
          g = grant_q.pop_front();
          check("grant", {owner, m_a, m_d, m_we, m_rd}, {g.own, g.a, g.d, g.we, g.rd});
        end
      end
      prev_mreq = m_we | m_rd;
      if (c_ready || x_ready) begin
        if (done_q.size() == 0) begin
          check("unexpected_ready", {c_ready, x_ready}, 2'b00);
        end else begin
          e = done_q.pop_front();
          check("ready_port", {c_ready, x_ready}, e.port ? 2'b01 : 2'b10);
          if (e.chk) check("spo", e.port ? x_spo : c_spo, e.spo);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_a = 0; c_d = 0; x_a = 0; x_d = 0; m_spo = 32'hDEAD_DEAD;
    ctl_en = 1; ctl_lat = 4; ctl_data = 0;
    do_reset();

    // reset state
    check("rst_m_we",  m_we, 0);
    check("rst_m_rd",  m_rd, 0);
    check("rst_busy",  busy, 0);
    check("rst_owner", owner, 0);
    check("rst_ready", {c_ready, x_ready}, 0);
    check("rst_m_a",   m_a, 0);
    check("rst_m_d",   m_d, 0);
    check("rst_spo",   {c_spo, x_spo}, 0);

    // single CPU read, controller answers 4 cycles after m_rd
    ctl_lat = 4; ctl_data = 32'hEAFE_BAAE;   // ^ 0x2000_0010 = 0xCAFEBABE
    exp_grant(0, 32'h2000_0010, 0, 0, 1);
    exp_done(0, 32'hCAFE_BABE, 1);
    push_req(0, 32'h2000_0010, 0, 0, 1);
    tick();
    tick();
    check("t1_busy_inflight", {busy, owner, m_rd}, 3'b101);
    wait_done("t1_done", 40);
    tick();
    check("t1_busy_after", busy, 0);
    check("t1_spo_held", c_spo, 32'hCAFE_BABE);
    check("t1_x_ready", x_ready, 0);

    // simultaneous CPU write and DMA read
    do_reset();
    ctl_lat = 2; ctl_data = 32'h5555_0000;
`ifdef MAINM_ARB_RR_EN
    exp_grant(0, 32'h100, 32'h11, 1, 0); exp_done(0, 0, 0);
    exp_grant(1, 32'h200, 0, 0, 1);      exp_done(1, 32'h5555_0200, 1);
`else
    exp_grant(1, 32'h200, 0, 0, 1);      exp_done(1, 32'h5555_0200, 1);
    exp_grant(0, 32'h100, 32'h11, 1, 0); exp_done(0, 0, 0);
`endif
    push_req(0, 32'h100, 32'h11, 1, 0);
    push_req(1, 32'h200, 0, 0, 1);
    wait_done("t2_both", 60);

    // we and rd together on one port is a write
    exp_grant(1, 32'h300, 32'h33, 1, 0); exp_done(1, 0, 0);
    push_req(1, 32'h300, 32'h33, 1, 1);
    wait_done("t2_we_rd", 40);

    // continuous contention, 5 transactions per port
    do_reset();
    cpu_gr = 0; dma_gr = 0;
    for (int i = 0; i < 5; i++) begin
      push_req(0, 32'h1000 + 4 * i, 0, 0, 1);
      push_req(1, 32'h3000 + 4 * i, 0, 0, 1);
    end
`ifdef MAINM_ARB_RR_EN
    for (int i = 0; i < 5; i++) begin
      exp_grant(0, 32'h1000 + 4 * i, 0, 0, 1); exp_done(0, 32'h5555_1000 + 4 * i, 1);
      exp_grant(1, 32'h3000 + 4 * i, 0, 0, 1); exp_done(1, 32'h5555_3000 + 4 * i, 1);
    end
`else
    for (int i = 0; i < 5; i++) begin
      exp_grant(1, 32'h3000 + 4 * i, 0, 0, 1); exp_done(1, 32'h5555_3000 + 4 * i, 1);
    end
    for (int i = 0; i < 5; i++) begin
      exp_grant(0, 32'h1000 + 4 * i, 0, 0, 1); exp_done(0, 32'h5555_1000 + 4 * i, 1);
    end
`endif
    wait_done("t3_contention", 200);
    check("t3_cpu_grants", cpu_gr, 5);
    check("t3_dma_grants", dma_gr, 5);

    // address change after grant is ignored
    ctl_lat = 6;
    exp_grant(0, 32'h40, 0, 0, 1); exp_done(0, 32'h5555_0040, 1);
    push_req(0, 32'h40, 0, 0, 1);
    tick();
    tick();
    c_a = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_m_a_stable", {m_rd, m_a}, {1'b1, 32'h40});
    end
    wait_done("t4_done", 40);

    // reset during WAIT, then a late m_ready
    ctl_en = 0; man_ready = 0; ctl_data = 32'h7777_7777;
    exp_grant(0, 32'h500, 0, 0, 1);
    push_req(0, 32'h500, 0, 0, 1);
    tick(); tick(); tick();
    check("t5_in_wait", {busy, m_rd}, 2'b11);
    rst_n = 0; c_rd = 0; c_act = 0;
    tick();
    check("t5_rst", {m_rd, busy, m_a}, 0);
    rst_n = 1; man_ready = 1;
    tick();
    #1;
    check("t5_late_ready", {c_ready, x_ready}, 0);
    man_ready = 0;
    tick();
    check("t5_after", {busy, m_rd, m_we}, 0);

    // stray m_ready in IDLE
    man_ready = 1;
    tick();
    #1;
    check("t6_stray_ready", {c_ready, x_ready, c_spo}, 0);
    man_ready = 0;
    tick();
    check("t6_idle", {busy, m_we, m_rd, x_spo}, 0);

    // arbiter still serves requests afterwards
    ctl_en = 1; ctl_lat = 3; ctl_data = 32'h1234_0000;
    exp_grant(1, 32'h600, 0, 0, 1); exp_done(1, 32'h1234_0600, 1);
    push_req(1, 32'h600, 0, 0, 1);
    wait_done("t6_recover", 40);

    tick(); tick();
    check("leftover_expect", {grant_q.size(), done_q.size()}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mainm_arbiter.md
# mainm_arbiter

Two-port arbiter sharing the main-memory (PSRAM) controller between the CPU-side path and a DMA master such as the video frame fetcher. It sits between the serial-boot passthrough and the memory controller. It uses the same `a`/`d`/`we`/`rd`/`spo`/`ready` single-outstanding bus on every side. One transaction is in flight at a time, and the arbiter holds the grant until the controller returns `ready`.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  main clock (`clk_main` domain).
- `rst_n`  in  1  synchronous reset, active-low.
- `c_a`, `c_d`  in  AW/DW  CPU-port address and write data.
- `c_we`, `c_rd`  in  1  CPU-port write and read request, level, held until `c_ready`.
- `c_spo`  out  DW  CPU-port read data.
- `c_ready`  out  1  CPU-port one-cycle completion pulse.
- `x_a`, `x_d`, `x_we`, `x_rd`, `x_spo`, `x_ready`: DMA port, same semantics as the CPU port.
- `m_a`, `m_d`  out  AW/DW  to memory controller, registered.
- `m_we`, `m_rd`  out  1  to memory controller, registered, held until `m_ready`.
- `m_spo`  in  DW  controller read data.
- `m_ready`  in  1  controller completion pulse.
- `owner`  out  1  0 = CPU, 1 = DMA; valid while `busy`.
- `busy`  out  1  a transaction is in flight.

## Operation
- State machine: IDLE → GRANT → WAIT → RELEASE → IDLE.
- **IDLE.** A port is requesting when `we|rd` is high. If only one port requests, it wins. If both request, the priority rule applies (see Configuration).
  - The winner's `a`, `d`, `we`, `rd` are latched into `m_*`.
  - `owner` is set and `busy` goes to 1.
  - Next state is WAIT. GRANT is folded into the IDLE→WAIT edge; there is no separate cycle.
- **WAIT.** `m_*` is held stable.
  - On `m_ready`: `m_spo` is forwarded combinationally to the owner's `spo`, the owner's `ready` pulses in the same cycle, and `m_we`/`m_rd` are cleared.
  - Next state is RELEASE.
- **RELEASE.** One dead cycle; requests are not sampled. This lets the requester drop `we`/`rd` after its `ready` without being re-granted. Next state is IDLE.
- The non-owner's `ready` is always 0. The non-owner's `spo` is the last value delivered to it; it is never updated mid-transaction.
- If both `we` and `rd` are high on one port, the request is treated as a write: `m_we` = 1, `m_rd` = 0.
- A requester must not change `a`/`d` while requesting. The arbiter latches at grant and ignores later changes.
- An `m_ready` outside WAIT is ignored. This covers the controller finishing after a reset.
- **Reset** (`rst_n` = 0 at a clock edge), including mid-transaction:
  - State returns to IDLE.
  - `m_we`, `m_rd`, `busy`, `owner`, `c_ready`, `x_ready` all go to 0.
  - `m_a`, `m_d`, `c_spo`, `x_spo` go to 0.
  - The round-robin pointer goes to 0 (CPU favoured next).

## Timing
- **Grant latency.** A request seen in IDLE at edge N drives `m_we`/`m_rd` from cycle N+1.
- **Completion.** `m_ready` at cycle K gives the owner's `ready` at cycle K (zero added latency). Earliest re-arbitration is K+2.
- **Overhead.** Minimum 3 cycles per transaction beyond controller latency: grant, ready, release.
- **No starvation.** A losing port waits at most one full transaction of the other port, but only when round-robin is compiled in.

## Configuration
- `MAINM_ARB_RR_EN`
  - **Defined:** round-robin. A 1-bit pointer names the port favoured on contention and flips to the non-winner after each grant made under contention. An uncontended grant also sets the pointer to the other port.
  - **Undefined:** fixed priority, DMA over CPU. This keeps video fetch deadlines; the CPU can starve under continuous DMA. The pointer logic is not instantiated.

## Structure
- Shared package `mainm_arb_pkg`:
  - state encoding: `ARB_IDLE`, `ARB_WAIT`, `ARB_RELEASE`
  - port ids: `PORT_CPU` = 0, `PORT_DMA` = 1
- Sub-module `mainm_arb_pick`: combinational winner select from two request bits plus pointer/mode. Its output is the winner id.
- Registered `m_*` outputs, FSM and pointer live in the top module.

## Test plan
- **Single CPU read.** `c_rd` = 1, `c_a` = 0x2000_0010, controller returns `m_spo` = 0xCAFEBABE with `m_ready` 4 cycles after `m_rd`. Expected: `c_ready` pulses once, `c_spo` = 0xCAFEBABE, `x_ready` = 0, `busy` = 0 two cycles later.
- **Simultaneous requests, both builds.** `c_we` (`c_a` = 0x100, `c_d` = 0x11) and `x_rd` (`x_a` = 0x200) asserted together. Expected:
  - with `MAINM_ARB_RR_EN`: CPU granted first (`m_a` = 0x100), then DMA.
  - without: DMA first (`m_a` = 0x200), then CPU.
- **Continuous contention, RR build.** Both ports request back-to-back for 10 transactions. Expected: grants strictly alternate, so each port gets 5.
- **Address change after grant.** Change `c_a` from 0x40 to 0x80 after grant. Expected: `m_a` stays 0x40 until `m_ready`.
- **Reset mid-transaction.** `rst_n` low during WAIT, then a late `m_ready`. Expected: `m_rd` = 0, `busy` = 0, no `c_ready`/`x_ready` pulse.
- **Stray ready in IDLE.** `m_ready` pulses in IDLE with no request pending. Expected: no state change, no port `ready`.
